// File: rtl/me_dmem_ctrl.sv
// Memory-stage data SRAM sequencer: one outstanding access,
// request held until addr_ok, response buffered until ME retires it.
module me_dmem_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ex_req_valid,
    input  logic              ex_wr,
    input  logic [1:0]        ex_size,
    input  logic [3:0]        ex_wstrb,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_wdata,
    output logic              ex_req_accept,
    input  logic              me_consume,
    output logic              me_data_valid,
    output logic [DATA_W-1:0] me_rdata,
    input  logic              flush,
    output logic              busy,
    output logic              data_sram_req,
    output logic              data_sram_wr,
    output logic [1:0]        data_sram_size,
    output logic [3:0]        data_sram_wstrb,
    output logic [ADDR_W-1:0] data_sram_addr,
    output logic [DATA_W-1:0] data_sram_wdata,
    input  logic              data_sram_addr_ok,
    input  logic              data_sram_data_ok,
    input  logic [DATA_W-1:0] data_sram_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } state_t;

    state_t              state;
    logic                cancel;
    logic                r_wr;
    logic [1:0]          r_size;
    logic [3:0]          r_wstrb;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                can_take;
    logic                in_req;

    assign can_take = (state == IDLE)
                    | ((state == HOLD) & me_consume);

    // resetn gate keeps accept low while reset is held
    assign ex_req_accept = resetn & ex_req_valid
                         & ~flush & can_take;

    assign in_req          = (state == REQ);
    assign busy            = (state != IDLE);
    assign me_data_valid   = (state == HOLD);
    assign data_sram_req   = in_req;
    assign data_sram_wr    = in_req & r_wr;
    assign data_sram_size  = in_req ? r_size  : '0;
    assign data_sram_wstrb = in_req ? r_wstrb : '0;
    assign data_sram_addr  = in_req ? r_addr  : '0;
    assign data_sram_wdata = in_req ? r_wdata : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            cancel   <= 1'b0;
            r_wr     <= 1'b0;
            r_size   <= '0;
            r_wstrb  <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            me_rdata <= '0;
        end else if (ex_req_accept) begin
            state   <= REQ;
            cancel  <= 1'b0;
            r_wr    <= ex_wr;
            r_size  <= ex_size;
            r_wstrb <= ex_wr ? ex_wstrb : 4'b0000;
            r_addr  <= ex_addr;
            r_wdata <= ex_wdata;
        end else begin
            unique case (state)
                IDLE: ;
                REQ: begin
                    // bus request is never withdrawn
                    if (flush)
                        cancel <= 1'b1;
                    if (data_sram_addr_ok)
                        state <= WAIT;
                end
                WAIT: begin
                    if (data_sram_data_ok) begin
                        if (cancel | flush) begin
                            state <= IDLE;
                        end else begin
                            state    <= HOLD;
                            me_rdata <= data_sram_rdata;
                        end
                    end else if (flush) begin
                        cancel <= 1'b1;
                    end
                end
                HOLD: begin
                    if (flush | me_consume)
                        state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_me_dmem_ctrl.sv
// Directed bench for me_dmem_ctrl; a monitor checks retired
// read data against a queue of hand-computed expectations.
module tb_me_dmem_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ex_req_valid = 1'b0;
    logic        ex_wr = 1'b0;
    logic [1:0]  ex_size = '0;
    logic [3:0]  ex_wstrb = '0;
    logic [31:0] ex_addr = '0;
    logic [31:0] ex_wdata = '0;
    logic        ex_req_accept;
    logic        me_consume = 1'b0;
    logic        me_data_valid;
    logic [31:0] me_rdata;
    logic        flush = 1'b0;
    logic        busy;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok = 1'b0;
    logic        data_sram_data_ok = 1'b0;
    logic [31:0] data_sram_rdata = '0;

    int n_chk = 0;
    int n_pass = 0;
    logic [31:0] exp_q[$];

    me_dmem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .ex_req_valid     (ex_req_valid),
        .ex_wr            (ex_wr),
        .ex_size          (ex_size),
        .ex_wstrb         (ex_wstrb),
        .ex_addr          (ex_addr),
        .ex_wdata         (ex_wdata),
        .ex_req_accept    (ex_req_accept),
        .me_consume       (me_consume),
        .me_data_valid    (me_data_valid),
        .me_rdata         (me_rdata),
        .flush            (flush),
        .busy             (busy),
        .data_sram_req    (data_sram_req),
        .data_sram_wr     (data_sram_wr),
        .data_sram_size   (data_sram_size),
        .data_sram_wstrb  (data_sram_wstrb),
        .data_sram_addr   (data_sram_addr),
        .data_sram_wdata  (data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok),
        .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata  (data_sram_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic tk();
        @(posedge clk);
        #1;
    endtask

    task automatic nx();
        @(negedge clk);
    endtask

    task automatic req_in(input logic wr,
                          input logic [1:0] sz,
                          input logic [3:0] st,
                          input logic [31:0] a,
                          input logic [31:0] d);
        ex_req_valid = 1'b1;
        ex_wr        = wr;
        ex_size      = sz;
        ex_wstrb     = st;
        ex_addr      = a;
        ex_wdata     = d;
    endtask

    // Monitor: retirement of a buffered response
    always @(negedge clk) begin
        if (resetn && me_data_valid && me_consume && !flush) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_rsp: got %h want none",
                         me_rdata);
            end else begin
                chk("rsp_rdata", me_rdata, exp_q.pop_front());
            end
        end
    end

    initial begin
        // reset state
        #2;
        ex_req_valid = 1'b1;
        #1;
        chk("rst_accept", {31'b0, ex_req_accept}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_req", {31'b0, data_sram_req}, 32'd0);
        chk("rst_rdata", me_rdata, 32'd0);
        ex_req_valid = 1'b0;
        tk();
        resetn = 1'b1;

        // 1: load word, zero-wait memory
        tk();
        req_in(1'b0, 2'd2, 4'hf, 32'h1c000100, 32'h0);
        nx(); chk("t1_accept", {31'b0, ex_req_accept}, 32'd1);
        tk();
        ex_req_valid = 1'b0;
        data_sram_addr_ok = 1'b1;
        nx();
        chk("t1_req", {31'b0, data_sram_req}, 32'd1);
        chk("t1_addr", data_sram_addr, 32'h1c000100);
        chk("t1_wstrb", {28'b0, data_sram_wstrb}, 32'd0);
        chk("t1_size", {30'b0, data_sram_size}, 32'd2);
        tk();
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'hdeadbeef;
        exp_q.push_back(32'hdeadbeef);
        nx();
        chk("t1_wait_req", {31'b0, data_sram_req}, 32'd0);
        chk("t1_wait_dv", {31'b0, me_data_valid}, 32'd0);
        tk();
        data_sram_data_ok = 1'b0;
        me_consume = 1'b1;
        nx(); chk("t1_dv", {31'b0, me_data_valid}, 32'd1);
        tk();
        me_consume = 1'b0;
        nx(); chk("t1_idle", {31'b0, busy}, 32'd0);

        // 2: store byte, addr_ok after 3 wait cycles
        tk();
        req_in(1'b1, 2'd0, 4'b0100, 32'h1c000202, 32'h00ab0000);
        nx(); chk("t2_accept", {31'b0, ex_req_accept}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            tk();
            req_in(1'b0, 2'd2, 4'hf, 32'h1c0002f0, 32'h1);
            data_sram_addr_ok = (i == 3);
            nx();
            chk("t2_req", {31'b0, data_sram_req}, 32'd1);
            chk("t2_wr", {31'b0, data_sram_wr}, 32'd1);
            chk("t2_addr", data_sram_addr, 32'h1c000202);
            chk("t2_wdata", data_sram_wdata, 32'h00ab0000);
            chk("t2_wstrb", {28'b0, data_sram_wstrb}, 32'h4);
            chk("t2_size", {30'b0, data_sram_size}, 32'd0);
            chk("t2_blk", {31'b0, ex_req_accept}, 32'd0);
        end
        tk();
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h12345678;
        exp_q.push_back(32'h12345678);
        nx(); chk("t2_wait_blk", {31'b0, ex_req_accept}, 32'd0);
        tk();
        data_sram_data_ok = 1'b0;
        ex_req_valid = 1'b0;
        nx(); chk("t2_hold", {31'b0, me_data_valid}, 32'd1);
        tk();
        nx(); chk("t2_hold2", {31'b0, me_data_valid}, 32'd1);
        tk();
        me_consume = 1'b1;
        tk();
        me_consume = 1'b0;
        nx(); chk("t2_idle", {31'b0, busy}, 32'd0);

        // 3: flush while request waits for addr_ok
        tk();
        req_in(1'b0, 2'd2, 4'h0, 32'h1c000300, 32'h0);
        tk();
        flush = 1'b1;
        nx();
        chk("t3_req1", {31'b0, data_sram_req}, 32'd1);
        chk("t3_blk1", {31'b0, ex_req_accept}, 32'd0);
        tk();
        flush = 1'b0;
        nx();
        chk("t3_req2", {31'b0, data_sram_req}, 32'd1);
        chk("t3_blk2", {31'b0, ex_req_accept}, 32'd0);
        tk();
        data_sram_addr_ok = 1'b1;
        nx(); chk("t3_req3", {31'b0, data_sram_req}, 32'd1);
        tk();
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'hbad0bad0;
        nx();
        chk("t3_blk4", {31'b0, ex_req_accept}, 32'd0);
        chk("t3_dv4", {31'b0, me_data_valid}, 32'd0);
        tk();
        data_sram_data_ok = 1'b0;
        ex_req_valid = 1'b0;
        nx();
        chk("t3_idle", {31'b0, busy}, 32'd0);
        chk("t3_dv5", {31'b0, me_data_valid}, 32'd0);
        chk("t3_rdata", me_rdata, 32'h12345678);

        // 4: flush coincident with data_ok
        tk();
        req_in(1'b0, 2'd2, 4'h0, 32'h1c000400, 32'h0);
        tk();
        ex_req_valid = 1'b0;
        data_sram_addr_ok = 1'b1;
        tk();
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h55aa55aa;
        flush = 1'b1;
        tk();
        data_sram_data_ok = 1'b0;
        flush = 1'b0;
        nx();
        chk("t4_idle", {31'b0, busy}, 32'd0);
        chk("t4_dv", {31'b0, me_data_valid}, 32'd0);
        chk("t4_rdata", me_rdata, 32'h12345678);

        // 5: back-to-back via consume + accept in HOLD
        tk();
        req_in(1'b0, 2'd2, 4'h0, 32'h1c000500, 32'h0);
        tk();
        ex_req_valid = 1'b0;
        data_sram_addr_ok = 1'b1;
        tk();
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h11111111;
        exp_q.push_back(32'h11111111);
        tk();
        data_sram_data_ok = 1'b0;
        me_consume = 1'b1;
        req_in(1'b1, 2'd2, 4'hf, 32'h1c000504, 32'hcafef00d);
        nx(); chk("t5_accept", {31'b0, ex_req_accept}, 32'd1);
        tk();
        me_consume = 1'b0;
        ex_req_valid = 1'b0;
        data_sram_addr_ok = 1'b1;
        nx();
        chk("t5_req", {31'b0, data_sram_req}, 32'd1);
        chk("t5_wr", {31'b0, data_sram_wr}, 32'd1);
        chk("t5_addr", data_sram_addr, 32'h1c000504);
        chk("t5_wdata", data_sram_wdata, 32'hcafef00d);
        chk("t5_wstrb", {28'b0, data_sram_wstrb}, 32'hf);
        tk();
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h0;
        exp_q.push_back(32'h0);
        tk();
        data_sram_data_ok = 1'b0;
        me_consume = 1'b1;
        tk();
        me_consume = 1'b0;

        // 6: flush in HOLD drops buffer, consume ignored
        tk();
        req_in(1'b0, 2'd2, 4'h0, 32'h1c000700, 32'h0);
        tk();
        ex_req_valid = 1'b0;
        data_sram_addr_ok = 1'b1;
        tk();
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h77777777;
        tk();
        data_sram_data_ok = 1'b0;
        flush = 1'b1;
        me_consume = 1'b1;
        tk();
        flush = 1'b0;
        me_consume = 1'b0;
        nx();
        chk("t6_idle", {31'b0, busy}, 32'd0);
        chk("t6_dv", {31'b0, me_data_valid}, 32'd0);

        // 7: async reset mid-WAIT, then a stale data_ok
        tk();
        req_in(1'b0, 2'd2, 4'h0, 32'h1c000600, 32'h0);
        tk();
        data_sram_addr_ok = 1'b1;
        tk();
        data_sram_addr_ok = 1'b0;
        nx(); chk("t7_wait", {31'b0, busy}, 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("t7_busy", {31'b0, busy}, 32'd0);
        chk("t7_accept", {31'b0, ex_req_accept}, 32'd0);
        chk("t7_req", {31'b0, data_sram_req}, 32'd0);
        chk("t7_rdata", me_rdata, 32'd0);
        tk();
        ex_req_valid = 1'b0;
        resetn = 1'b1;
        tk();
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h99999999;
        tk();
        data_sram_data_ok = 1'b0;
        nx();
        chk("t7_late_busy", {31'b0, busy}, 32'd0);
        chk("t7_late_dv", {31'b0, me_data_valid}, 32'd0);

        tk();
        tk();
        chk("q_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/me_dmem_ctrl.md
Name: me_dmem_ctrl

Overview:
- Sequencer for the memory stage's data-SRAM accesses; sits between the EX/ME pipeline stages and the sram-like data port (req/addr_ok/data_ok handshake).
- Captures one load/store from EX, holds request fields stable on the bus until addr_ok, waits for data_ok, then buffers the response until ME retires it.
- Discards responses of requests cancelled by exception/ertn flush.
- At most one access outstanding.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
ex_req_valid  in  1  EX holds a valid memory op ready to advance
ex_wr  in  1  1=store, 0=load
ex_size  in  2  0=byte, 1=half, 2=word
ex_wstrb  in  4  byte enables for stores
ex_addr  in  ADDR_W  access address
ex_wdata  in  DATA_W  store data
ex_req_accept  out  1  request captured; EX may advance into ME this cycle
me_consume  in  1  ME moves its instruction to WB this cycle
me_data_valid  out  1  response buffered and available to ME
me_rdata  out  DATA_W  buffered read data (raw word; ME does byte/half extraction)
flush  in  1  excp_flush | ertn_flush
busy  out  1  state != IDLE
data_sram_req  out  1  request valid
data_sram_wr  out  1  write
data_sram_size  out  2  size
data_sram_wstrb  out  4  byte enables
data_sram_addr  out  ADDR_W  address
data_sram_wdata  out  DATA_W  write data
data_sram_addr_ok  in  1  request accepted by memory
data_sram_data_ok  in  1  response valid
data_sram_rdata  in  DATA_W  read data

Behaviour:
- Reset (resetn=0, async): state=IDLE, cancel=0, all captured request fields=0, me_rdata=0. Every output is 0 during reset.
- States: IDLE, REQ (bus request driven), WAIT (addr accepted, awaiting data_ok), HOLD (response buffered).
- ex_req_accept = ex_req_valid & !flush & (state==IDLE | (state==HOLD & me_consume)). Combinational.
- On accept: latch wr/size/wstrb/addr/wdata, clear cancel, next state=REQ.
- Read requests latch wstrb as 4'b0 regardless of ex_wstrb.
- REQ: data_sram_req=1 and all data_sram_* fields driven from latches, stable until addr_ok.
  - addr_ok -> WAIT.
  - A request is never withdrawn, even on flush.
- WAIT: data_sram_req=0.
  - data_ok & !cancel -> HOLD; me_rdata <= data_sram_rdata. Stores capture rdata too; the value is don't-care to ME.
  - data_ok & cancel -> IDLE; response dropped.
- HOLD: me_data_valid=1.
  - me_consume & no new accept -> IDLE.
  - me_consume & accept -> REQ (back-to-back).
  - No consume -> stay in HOLD.
- data_sram_* fields are 0 outside REQ.
- Latency, zero-wait memory: accept at cycle N -> req at N+1 (addr_ok same cycle) -> data_ok earliest N+2 -> me_data_valid at N+3.
- Flush:
  - IDLE: blocks accept; no state change.
  - REQ: set cancel; stay until addr_ok, then WAIT. Flush coincident with addr_ok -> WAIT with cancel=1.
  - WAIT: set cancel. Flush coincident with data_ok -> IDLE, no HOLD, me_rdata unchanged.
  - HOLD: -> IDLE, buffer dropped; me_consume that cycle is ignored.
  - Repeated flush while cancel=1: no effect.
- data_ok outside WAIT and addr_ok outside REQ are ignored; no state change.
- me_consume outside HOLD is ignored.
- A cancelled access never raises me_data_valid.
- Accept is blocked until its cancelled predecessor's data_ok is drained.
- Invariant: outstanding count ≤ 1.
- No alignment checking; ALE is detected upstream in EX.

Test Plan:
- Load word, zero-wait memory: accept addr 0x1c000100 at N; req at N+1 with addr_ok=1; data_ok at N+2 with rdata 0xdeadbeef -> me_data_valid=1, me_rdata=0xdeadbeef at N+3; me_consume at N+3 -> IDLE at N+4.
- Store byte, addr_ok delayed 3 cycles: wstrb=4'b0100, wdata 0x00ab0000 -> req and all fields held constant for 4 cycles; ex_req_accept=0 for new requests throughout; HOLD after data_ok.
- Flush in REQ: flush at N+1 while addr_ok=0; addr_ok at N+3; data_ok at N+4 -> req stays 1 until N+3; me_data_valid never 1; state IDLE at N+5; accept blocked until then.
- Flush coincident with data_ok in WAIT -> IDLE next cycle, me_data_valid=0, me_rdata keeps previous value.
- Back-to-back: HOLD with me_consume=1 and ex_req_valid=1 -> ex_req_accept=1 same cycle; REQ next cycle with new fields.
- Async reset asserted mid-WAIT -> all outputs 0 immediately; after deassertion a late data_ok is ignored and state stays IDLE.
